// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller.
// A Moore FSM steps each instruction through fetch, decode, execute, memory
// and writeback states. It drives every datapath select and write enable,
// waits on a memory ready handshake with an optional timeout, and counts
// retired instructions.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OP,
  input  logic [5:0]       FUNCT,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             InstrDone,
  output logic             Fault,
  output logic [CNT_W-1:0] InstrCount
);

  // State encodings (also exported on State for debug)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEM_ADR = 4'd2;
  localparam logic [3:0] S_MEM_RD  = 4'd3;
  localparam logic [3:0] S_MEM_WB  = 4'd4;
  localparam logic [3:0] S_MEM_WR  = 4'd5;
  localparam logic [3:0] S_EXEC_R  = 4'd6;
  localparam logic [3:0] S_EXEC_I  = 4'd7;
  localparam logic [3:0] S_ALU_WB  = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_JAL     = 4'd11;
  localparam logic [3:0] S_JR      = 4'd12;
  localparam logic [3:0] S_FAULT   = 4'd15;

  // Opcodes recognised in DECODE
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  // ALUOp codes shared with ALUControl
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_ORI  = 4'b0010;
  localparam logic [3:0] ALU_ANDI = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;
  localparam logic [3:0] ALU_SW   = 4'b0101;
  localparam logic [3:0] ALU_LW   = 4'b0110;
  localparam logic [3:0] ALU_BEQ  = 4'b0111;
  localparam logic [3:0] ALU_BNE  = 4'b1000;
  localparam logic [3:0] ALU_R    = 4'b1111;

  // The wait counter only has to reach MEM_TIMEOUT-1: the timeout fires in
  // the cycle whose missing ready would make the count equal MEM_TIMEOUT,
  // i.e. after MEM_TIMEOUT consecutive not-ready cycles.
  localparam int         WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int         LAST_I    = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LAST_I);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};

  logic [3:0]       r_state;
  logic [3:0]       w_state_next;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_next;
  logic [CNT_W-1:0] r_instr_count;

  logic       w_mem_state;
  logic       w_timeout;

  logic       w_pc_write;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [3:0] w_alu_op;
  logic [1:0] w_pc_source;
  logic       w_instr_done;
  logic       w_fault;

  // States that wait on the memory handshake
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
  // A ready in the limit cycle wins, so the timeout requires MemReady low
  assign w_timeout   = (MEM_TIMEOUT != 0) && !MemReady && (r_wait == WAIT_LAST);

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (MemReady)       w_state_next = S_DECODE;
        else if (w_timeout) w_state_next = S_FAULT;
      end
      S_DECODE: begin
        case (OP)
          OP_RTYPE: w_state_next = (FUNCT == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW: w_state_next = S_MEM_ADR;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: w_state_next = S_EXEC_I;
          OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
          OP_J:     w_state_next = S_JUMP;
          OP_JAL:   w_state_next = S_JAL;
          default:  w_state_next = S_FAULT;
        endcase
      end
      S_MEM_ADR: w_state_next = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (MemReady)       w_state_next = S_MEM_WB;
        else if (w_timeout) w_state_next = S_FAULT;
      end
      S_MEM_WR: begin
        if (MemReady)       w_state_next = S_FETCH;
        else if (w_timeout) w_state_next = S_FAULT;
      end
      S_EXEC_R, S_EXEC_I: w_state_next = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: w_state_next = S_FETCH;
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_FAULT;
    endcase
  end

  // Wait counter: restarts on any state change, counts not-ready cycles
  always_comb begin
    w_wait_next = r_wait;
    if (w_state_next != r_state) begin
      w_wait_next = '0;
    end else if (w_mem_state && !MemReady && (r_wait != WAIT_MAX)) begin
      w_wait_next = r_wait + 1'b1;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else begin
      r_wait <= w_wait_next;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_count <= '0;
    end else if (w_instr_done) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  // Moore output decode per state, qualified by OP/Zero/MemReady
  always_comb begin
    w_pc_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 2'b00;
    w_mem_to_reg = 2'b00;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 4'b0000;
    w_pc_source  = 2'b00;
    w_instr_done = 1'b0;
    w_fault      = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC + 4 computed every cycle; only latched when memory delivers
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_alu_op    = ALU_ADD;
        w_ir_write  = MemReady;
        w_pc_write  = MemReady;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut
        w_alu_src_b = 2'b11;
        w_alu_op    = ALU_ADD;
      end
      S_MEM_ADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = (OP == OP_LW) ? ALU_LW : ALU_SW;
      end
      S_MEM_RD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
      end
      S_MEM_WB: begin
        w_mem_to_reg = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEM_WR: begin
        w_iord       = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = MemReady;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_R;
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        case (OP)
          OP_ORI:  w_alu_op = ALU_ORI;
          OP_ANDI: w_alu_op = ALU_ANDI;
          OP_LUI:  w_alu_op = ALU_LUI;
          default: w_alu_op = ALU_ADD;
        endcase
      end
      S_ALU_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = (OP == OP_RTYPE) ? 2'b01 : 2'b00;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = (OP == OP_BEQ) ? ALU_BEQ : ALU_BNE;
        w_pc_source  = 2'b01;
        w_pc_write   = (OP == OP_BEQ) ? Zero : !Zero;
        w_instr_done = 1'b1;
      end
      S_JUMP: begin
        w_pc_source  = 2'b10;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JAL: begin
        // $31 gets the PC already advanced in FETCH; new PC lands at the same edge
        w_pc_source  = 2'b10;
        w_pc_write   = 1'b1;
        w_reg_dst    = 2'b10;
        w_mem_to_reg = 2'b10;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JR: begin
        w_pc_source  = 2'b11;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_FAULT: begin
        w_fault = 1'b1;
      end
      default: begin
        w_fault = 1'b0;
      end
    endcase
  end

  // Every output is held at zero while reset is asserted
  assign PCWrite    = reset & w_pc_write;
  assign IorD       = reset & w_iord;
  assign MemRead    = reset & w_mem_read;
  assign MemWrite   = reset & w_mem_write;
  assign IRWrite    = reset & w_ir_write;
  assign RegDst     = reset ? w_reg_dst    : 2'b00;
  assign MemtoReg   = reset ? w_mem_to_reg : 2'b00;
  assign RegWrite   = reset & w_reg_write;
  assign ALUSrcA    = reset & w_alu_src_a;
  assign ALUSrcB    = reset ? w_alu_src_b  : 2'b00;
  assign ALUOp      = reset ? w_alu_op     : 4'b0000;
  assign PCSource   = reset ? w_pc_source  : 2'b00;
  assign State      = reset ? r_state      : 4'b0000;
  assign InstrDone  = reset & w_instr_done;
  assign Fault      = reset & w_fault;
  assign InstrCount = reset ? r_instr_count : '0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction expected
// cycle sequences are built from the instruction class and memory latency.
module tb_multicycle_control_fsm;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OP, FUNCT;
  logic        Zero, MemReady;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic        InstrDone, Fault;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [3:0]  ALUOp, State;
  logic [31:0] InstrCount;
  logic [24:0] obs;

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;

  multicycle_control_fsm #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .OP(OP), .FUNCT(FUNCT), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .State(State),
    .InstrDone(InstrDone), .Fault(Fault), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, InstrDone, Fault};

  // Control word the datapath expects in a given state, from the state table
  function automatic logic [24:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input logic zero, input logic mr);
    logic pcw, iord, mrd, mwr, irw, rw, asa, done, flt;
    logic [1:0] rd, m2r, asb, pcs;
    logic [3:0] aop;
    {pcw, iord, mrd, mwr, irw, rw, asa, done, flt} = '0;
    {rd, m2r, asb, pcs} = '0;
    aop = 4'd0;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; aop = 4'd1; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; aop = 4'd1; end
      2:  begin asa = 1; asb = 2'b10; aop = (op == 6'h23) ? 4'd6 : 4'd5; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin m2r = 2'b01; rw = 1; done = 1; end
      5:  begin iord = 1; mwr = 1; done = mr; end
      6:  begin asa = 1; aop = 4'hf; end
      7:  begin
            asa = 1; asb = 2'b10;
            aop = (op == 6'h0d) ? 4'd2 : (op == 6'h0c) ? 4'd3 :
                  (op == 6'h0f) ? 4'd4 : 4'd1;
          end
      8:  begin rw = 1; rd = (op == 6'h00) ? 2'b01 : 2'b00; done = 1; end
      9:  begin
            asa = 1; pcs = 2'b01; done = 1;
            aop = (op == 6'h04) ? 4'd7 : 4'd8;
            pcw = (op == 6'h04) ? zero : !zero;
          end
      10: begin pcs = 2'b10; pcw = 1; done = 1; end
      11: begin pcs = 2'b10; pcw = 1; rd = 2'b10; m2r = 2'b10; rw = 1; done = 1; end
      12: begin pcs = 2'b11; pcw = 1; done = 1; end
      15: begin flt = 1; end
      default: ;
    endcase
    return {pcw, iord, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, pcs,
            4'(st), done, flt};
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge
  task automatic step(input int st, input int mr, input int z, input string tag);
    logic [24:0] e;
    MemReady = (mr == 2) ? 1'($urandom_range(0, 1)) : mr[0];
    Zero     = (z == 2)  ? 1'($urandom_range(0, 1)) : z[0];
    @(negedge clk);
    e = exp_ctrl(st, OP, Zero, MemReady);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL ctrl_%s st=%0d observed=%h expected=%h", tag, st, obs, e);
    end
    total++;
    assert (InstrCount === model_cnt) else begin
      bad++;
      $error("FAIL count_%s observed=%0d expected=%0d", tag, InstrCount, model_cnt);
    end
    if (e[1]) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Memory wait phase: w not-ready cycles, faulting once the limit is hit
  task automatic mem_wait(input int st, input int w, input string tag, output bit flt);
    int n;
    n = (w < T) ? w : T;
    flt = 0;
    for (int i = 0; i < n; i++) step(st, 0, 2, tag);
    if (w >= T) begin
      step(15, 2, 2, tag);
      flt = 1;
    end
  endtask

  // Whole instruction from FETCH back to FETCH (or into FAULT)
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int z,
                           input int fw, input int mw, input string tag);
    bit flt;
    int c0;
    c0 = total;
    OP = op; FUNCT = fn;
    mem_wait(0, fw, tag, flt);
    if (!flt) begin
      step(0, 1, 2, tag);
      step(1, 2, 2, tag);
      case (op)
        6'h00: if (fn == 6'h08) step(12, 2, 2, tag);
               else begin step(6, 2, 2, tag); step(8, 2, 2, tag); end
        6'h23: begin
                 step(2, 2, 2, tag);
                 mem_wait(3, mw, tag, flt);
                 if (!flt) begin step(3, 1, 2, tag); step(4, 2, 2, tag); end
               end
        6'h2b: begin
                 step(2, 2, 2, tag);
                 mem_wait(5, mw, tag, flt);
                 if (!flt) step(5, 1, 2, tag);
               end
        6'h08, 6'h0d, 6'h0c, 6'h0f: begin step(7, 2, 2, tag); step(8, 2, 2, tag); end
        6'h04, 6'h05: step(9, 2, z, tag);
        6'h02: step(10, 2, 2, tag);
        6'h03: step(11, 2, 2, tag);
        default: step(15, 2, 2, tag);
      endcase
    end
    $display("instr %s op=%h funct=%h cycles=%0d count=%0d",
             tag, op, fn, (total - c0) / 2, model_cnt);
  endtask

  // Reset held low for three cycles with random inputs; outputs must be zero
  task automatic do_reset();
    reset = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      OP = 6'($urandom_range(0, 63));
      MemReady = 1'($urandom_range(0, 1));
      Zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      assert (obs === 25'd0 && InstrCount === 32'd0) else begin
        bad++;
        $error("FAIL reset_outputs observed=%h/%0d expected=0/0", obs, InstrCount);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    $display("reset released");
  endtask

  initial begin
    logic [5:0] ops [12];
    logic [5:0] op, fn;
    int k;
    ops = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h08, 6'h0d, 6'h0c, 6'h0f,
            6'h04, 6'h05, 6'h02, 6'h03};
    reset = 1'b0; OP = '0; FUNCT = '0; Zero = 1'b0; MemReady = 1'b0;

    do_reset();
    run_instr(6'h00, 6'h20, 2, 0, 0, "add");
    run_instr(6'h23, 6'h00, 2, 0, 2, "lw_wait2");
    run_instr(6'h04, 6'h00, 1, 0, 0, "beq_z1");
    run_instr(6'h04, 6'h00, 0, 0, 0, "beq_z0");
    run_instr(6'h05, 6'h00, 0, 0, 0, "bne_z0");
    run_instr(6'h05, 6'h00, 1, 0, 0, "bne_z1");
    run_instr(6'h03, 6'h00, 2, 0, 0, "jal");
    run_instr(6'h00, 6'h08, 2, 1, 0, "jr");
    run_instr(6'h2b, 6'h00, 2, 0, 3, "sw_wait3");
    // Ready arriving in the limit cycle wins over the timeout
    run_instr(6'h0d, 6'h00, 2, T - 1, 0, "ori_fetch_limit");
    run_instr(6'h23, 6'h00, 2, 0, T - 1, "lw_rd_limit");
    run_instr(6'h2b, 6'h00, 2, 0, T - 1, "sw_wr_limit");

    // Randomized legal instruction stream
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 11);
      op = ops[k];
      fn = 6'($urandom_range(0, 63));
      if (k == 1) fn = 6'h08;
      else if (op == 6'h00 && fn == 6'h08) fn = 6'h20;
      run_instr(op, fn, 2, $urandom_range(0, 3), $urandom_range(0, 4), "rand");
    end

    // Illegal opcode: FAULT held until reset
    run_instr(6'h3f, 6'h00, 2, 0, 0, "illegal");
    for (int i = 0; i < 20; i++) step(15, 2, 2, "fault_hold");
    do_reset();

    // Fetch never answered: FAULT after T not-ready cycles
    run_instr(6'h00, 6'h20, 2, T, 0, "fetch_timeout");
    for (int i = 0; i < 3; i++) step(15, 2, 2, "timeout_hold");
    do_reset();

    // Store write phase timing out
    run_instr(6'h2b, 6'h00, 2, 0, T, "sw_timeout");
    do_reset();

    // Reset asserted mid MEM_WR aborts the store immediately
    run_instr(6'h08, 6'h00, 2, 0, 0, "addi");
    OP = 6'h2b; FUNCT = 6'h00;
    step(0, 1, 2, "sw_abort");
    step(1, 2, 2, "sw_abort");
    step(2, 2, 2, "sw_abort");
    step(5, 0, 2, "sw_abort");
    MemReady = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    total++;
    assert (obs === 25'd0 && InstrCount === 32'd0) else begin
      bad++;
      $error("FAIL async_abort observed=%h/%0d expected=0/0", obs, InstrCount);
    end
    model_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    $display("reset released after abort");
    run_instr(6'h00, 6'h22, 2, 2, 0, "sub_after_abort");
    run_instr(6'h02, 6'h00, 2, 0, 0, "j");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Sequencing controller for the multicycle MIPS datapath, which has one shared memory port, IR, MDR, ALUOut and the PC register.
- A Moore FSM steps each instruction through FETCH / DECODE / EXECUTE / MEM / WRITEBACK.
- It drives all datapath selects and write enables, and handles variable-latency memory through a ready handshake.
- It flags illegal opcodes and memory timeouts, and counts retired instructions.
- ALUOp codes are identical to those consumed by ALUControl.

Parameters:
MEM_TIMEOUT, 15, max cycles waiting on MemReady in any memory state before FAULT; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
OP  input  6  opcode from IR (stable from DECODE to end of instruction).
FUNCT  input  6  funct field from IR.
Zero  input  1  ALU zero flag.
MemReady  input  1  memory has completed the current read/write this cycle.
PCWrite  output  1  PC register load enable.
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
MemRead  output  1  memory read strobe.
MemWrite  output  1  memory write strobe.
IRWrite  output  1  IR load enable.
RegDst  output  2  write register select: 00 = rt, 01 = rd, 10 = $31.
MemtoReg  output  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC.
RegWrite  output  1  register file write enable.
ALUSrcA  output  1  0 = PC, 1 = rs.
ALUSrcB  output  2  00 = rt, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
ALUOp  output  4  0001 add, 0010 ori, 0011 andi, 0100 lui, 0101 sw, 0110 lw, 0111 beq, 1000 bne, 1111 R-type.
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs (jr).
State  output  4  current state encoding (debug).
InstrDone  output  1  one-cycle pulse in the final cycle of every instruction.
Fault  output  1  high while in FAULT.
InstrCount  output  CNT_W  retired-instruction counter.

Behaviour:
Reset:
- State = FETCH (0), wait counter = 0, InstrCount = 0.
- While reset = 0, every output is forced to 0.
- Reset mid-instruction aborts the instruction immediately; no partial writes occur after the reset edge.

Output rules:
- Outputs are combinational decode of state plus OP, FUNCT, Zero and MemReady.
- Any output not listed for a state is 0.

State encodings:
- FETCH = 0, DECODE = 1, MEM_ADR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, EXEC_R = 6, EXEC_I = 7, ALU_WB = 8.
- BRANCH = 9, JUMP = 10, JAL = 11, JR = 12, FAULT = 15.

FETCH (0):
- MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 0001, PCSource = 00.
- IRWrite and PCWrite assert only in a cycle with MemReady = 1; that cycle transitions to DECODE.
- Otherwise the FSM stays in FETCH.

DECODE (1):
- ALUSrcA = 0, ALUSrcB = 11, ALUOp = 0001 (branch target into ALUOut).
- Next state by OP:
  - 00 with FUNCT 08 -> JR; other 00 -> EXEC_R.
  - 23/2b -> MEM_ADR.
  - 08/0d/0c/0f -> EXEC_I.
  - 04/05 -> BRANCH; 02 -> JUMP; 03 -> JAL.
  - Anything else -> FAULT.

MEM_ADR (2):
- ALUSrcA = 1, ALUSrcB = 10, ALUOp = 0110 (lw) or 0101 (sw).
- Next state MEM_RD for lw, MEM_WR for sw.

MEM_RD (3):
- IorD = 1, MemRead = 1.
- Holds until MemReady = 1, then -> MEM_WB.

MEM_WB (4):
- RegDst = 00, MemtoReg = 01, RegWrite = 1, InstrDone = 1 -> FETCH.

MEM_WR (5):
- IorD = 1, MemWrite = 1, held until MemReady.
- InstrDone = 1 in the MemReady cycle -> FETCH.

EXEC_R (6):
- ALUSrcA = 1, ALUSrcB = 00, ALUOp = 1111 -> ALU_WB.

EXEC_I (7):
- ALUSrcA = 1, ALUSrcB = 10, ALUOp per opcode (0001 / 0010 / 0011 / 0100) -> ALU_WB.

ALU_WB (8):
- RegWrite = 1, MemtoReg = 00.
- RegDst = 01 if OP = 0, else 00.
- InstrDone = 1 -> FETCH.

BRANCH (9):
- ALUSrcA = 1, ALUSrcB = 00, ALUOp = 0111 (beq) or 1000 (bne), PCSource = 01.
- PCWrite = (beq & Zero) | (bne & ~Zero).
- InstrDone = 1 -> FETCH.

JUMP (10):
- PCSource = 10, PCWrite = 1, InstrDone = 1 -> FETCH.

JAL (11):
- PCSource = 10, PCWrite = 1, RegDst = 10, MemtoReg = 10, RegWrite = 1.
- $31 receives the already-incremented PC (old value at the edge).
- InstrDone = 1 -> FETCH.

JR (12):
- PCSource = 11, PCWrite = 1, InstrDone = 1 -> FETCH.

FAULT (15):
- Fault = 1, all other controls 0.
- Exits only by reset.

Memory wait counter:
- Cleared on entry to FETCH, MEM_RD and MEM_WR.
- Increments each cycle in those states while MemReady = 0.
- If MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT with MemReady still 0 -> FAULT.
- MemReady in the same cycle the count reaches the limit wins: normal transition.

InstrCount:
- Increments on every InstrDone cycle and wraps at 2^CNT_W.
- Not incremented for aborted or faulted instructions.

Cycle counts with MemReady tied high:
- R-type/I-type ALU ops: 4 cycles.
- lw: 5 cycles. sw: 4 cycles.
- beq/bne, j, jal, jr: 3 cycles.

Test Plan:
- Reset low 3 cycles, release, MemReady = 1, add (OP 00, FUNCT 20) -> states 0, 1, 6, 8; RegWrite = 1 and RegDst = 01 in cycle 4; InstrDone pulse; InstrCount = 1.
- lw (OP 23), MemReady low for 2 cycles in MEM_RD -> states 0, 1, 2, 3, 3, 3, 4; MemtoReg = 01, RegWrite = 1 in the last cycle; 7 cycles total.
- beq with Zero = 1, then Zero = 0; bne with Zero = 0 -> PCWrite = 1, PCSource = 01 for the two taken cases; PCWrite = 0 for beq with Zero = 0.
- jal (OP 03) -> BRANCH skipped; in state 11: RegDst = 10, MemtoReg = 10, RegWrite = 1, PCWrite = 1, PCSource = 10.
- Illegal OP 3f -> FAULT after DECODE, Fault = 1 held for 20 cycles; MemReady never asserted in FETCH with MEM_TIMEOUT = 15 -> FAULT after 15 wait cycles; reset recovers to FETCH.
- Assert reset during MEM_WR with MemReady = 0 -> all outputs 0 immediately, State = 0, InstrCount = 0, no MemWrite after release until the next sw.
